// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream program loader: length header, payload writes to program RAM, checksum check
module boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    // Largest image that fits between BASE_ADDR and the top of memory.
    localparam logic [32:0]           LIMIT = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

    state_t                state, state_nxt;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            csum_q;
    logic [15:0]           len_full;
    logic                  accept;
    logic                  session_start;

    assign in_ready      = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
    assign busy          = in_ready;
    assign done          = (state == DONE);
    assign error         = (state == ERROR);
    assign cpu_hold      = (state != DONE);
    assign accept        = in_valid && in_ready;
    assign len_full      = {in_data, len_q[7:0]};
    assign session_start = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = LEN_LO;
            LEN_LO:            if (accept) state_nxt = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0)                state_nxt = CSUM;
                    else if ({17'd0, len_full} > LIMIT)   state_nxt = ERROR;
                    else                                  state_nxt = DATA;
                end
            end
            DATA:              if (accept && len_q == 16'd1) state_nxt = CSUM;
            CSUM:              if (accept) state_nxt = (in_data == csum_q) ? DONE : ERROR;
            default:           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // len_q holds the header, then counts down the payload bytes still expected.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= 16'd0;
            addr_q    <= BASE;
            csum_q    <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            if (session_start) begin
                csum_q <= 8'd0;
                addr_q <= BASE;
            end
            if (accept) begin
                case (state)
                    LEN_LO: len_q[7:0] <= in_data;
                    LEN_HI: len_q      <= len_full;
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= in_data;
                        csum_q    <= csum_q + in_data;
                        len_q     <= len_q - 16'd1;
                        // Hold on the final byte so the address never wraps past the top.
                        if (len_q != 16'd1) addr_q <= addr_q + ADDR_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - randomized self-checking bench for boot_loader against a byte-stream image model
module tb_boot_loader;
    localparam int AW   = 10;
    localparam int BASE = 0;

    logic          clk = 1'b0;
    logic          reset, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, mem_we, busy, done, error, cpu_hold;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] stream_q[$];

    boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), BASE);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_cpu_hold", 32'(cpu_hold), 1);
    endtask

    task automatic make_image(input int len, input bit bad);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd0;
        stream_q.delete();
        stream_q.push_back(len[7:0]);
        stream_q.push_back(len[15:8]);
        for (int j = 0; j < len; j++) begin
            b = 8'($urandom);
            sum = sum + b;
            stream_q.push_back(b);
        end
        stream_q.push_back(bad ? sum + 8'(1 + $urandom_range(0, 254)) : sum);
    endtask

    // Feeds stream_q as one session; abort_at >= 0 resets right after that byte index is accepted.
    task automatic run_session(input int gap_pct, input int start_at, input int abort_at);
        int len, i, cyc, data_sum;
        bit over, pend, exp_done;
        int paddr;
        logic [7:0] pdata;
        len  = int'(stream_q[0]) + 256 * int'(stream_q[1]);
        over = len > (1 << AW) - BASE;
        data_sum = 0;
        if (!over)
            for (int j = 2; j < 2 + len; j++) data_sum += int'(stream_q[j]);
        exp_done = !over && (stream_q.size() == len + 3) && (int'(stream_q[len + 2]) == data_sum % 256);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0; pend = 1'b0; cyc = 0; paddr = 0; pdata = 8'd0;
        while (i < stream_q.size() && cyc < 20000) begin
            check("mem_we", 32'(mem_we), 32'(pend));
            if (pend) begin
                check("mem_addr", 32'(mem_addr), 32'(paddr));
                check("mem_wdata", 32'(mem_wdata), 32'(pdata));
            end
            if (abort_at >= 0 && i > abort_at) break;
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            start = (i == start_at);
            in_data = in_valid ? stream_q[i] : 8'($urandom);
            pend = 1'b0;
            if (in_valid) begin
                check("in_ready", 32'(in_ready), 1);
                pend  = !over && i >= 2 && i < 2 + len;
                paddr = BASE + i - 2;
                pdata = stream_q[i];
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (cyc >= 20000) check("timeout", 1, 0);
        if (abort_at >= 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_reset_vals();
            @(negedge clk);
            check("post_rst_mem_we", 32'(mem_we), 0);
            return;
        end
        check("last_mem_we", 32'(mem_we), 32'(pend));
        if (pend) begin
            check("last_mem_addr", 32'(mem_addr), 32'(paddr));
            check("last_mem_wdata", 32'(mem_wdata), 32'(pdata));
        end
        for (int k = 0; k < 3; k++) begin
            check("end_done", 32'(done), 32'(exp_done));
            check("end_error", 32'(error), 32'(!exp_done));
            check("end_cpu_hold", 32'(cpu_hold), 32'(!exp_done));
            check("end_busy", 32'(busy), 0);
            check("end_in_ready", 32'(in_ready), 0);
            in_valid = 1'b1;
            in_data = 8'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
            check("end_mem_we", 32'(mem_we), 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        in_valid = 1'b1;
        in_data = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 0);
            check("idle_mem_we", 32'(mem_we), 0);
            check("idle_busy", 32'(busy), 0);
        end
        in_valid = 1'b0;

        stream_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        run_session(0, -1, -1);
        stream_q = '{8'h02, 8'h00, 8'hAA, 8'h01, 8'h00};
        run_session(0, -1, -1);
        stream_q = '{8'h00, 8'h00, 8'h00};
        run_session(0, -1, -1);
        stream_q = '{8'h00, 8'h00, 8'h05};
        run_session(0, -1, -1);
        stream_q = '{8'h01, 8'h04};
        run_session(0, -1, -1);
        make_image(1024, 1'b0);
        run_session(0, -1, -1);

        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, 40);
            make_image(len, k % 3 == 2);
            run_session(40, 2 + $urandom_range(0, len - 1), -1);
        end

        make_image(8, 1'b0);
        run_session(30, -1, 5);
        make_image(5, 1'b0);
        run_session(20, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10: width of the program-memory byte address.
REQ-002 The block SHALL have parameter BASE_ADDR, default 0: address written by the first payload byte.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  one-cycle pulse that begins a load session.
REQ-006 The block SHALL have port in_valid  input  1  upstream byte present.
REQ-007 The block SHALL have port in_data  input  8  upstream byte.
REQ-008 The block SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-009 The block SHALL have port mem_we  output  1  byte write strobe to program RAM.
REQ-010 The block SHALL have port mem_addr  output  ADDR_WIDTH  write address.
REQ-011 The block SHALL have port mem_wdata  output  8  write data.
REQ-012 The block SHALL have port busy  output  1  session in progress.
REQ-013 The block SHALL have port done  output  1  image loaded and checksum good.
REQ-014 The block SHALL have port error  output  1  session failed.
REQ-015 The block SHALL have port cpu_hold  output  1  keeps the CPU core in reset while high.

Function
REQ-016 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1; in_valid with in_ready=0 SHALL have no effect.
REQ-017 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
REQ-018 in_ready and busy SHALL be 1 exactly in LEN_LO, LEN_HI, DATA and CSUM, and 0 otherwise.
REQ-019 start in IDLE, DONE or ERROR SHALL move to LEN_LO, clear the checksum, load the write address with BASE_ADDR, and clear done and error; start in any busy state SHALL be ignored.
REQ-020 The LEN_LO acceptance SHALL store len[7:0], then move to LEN_HI.
REQ-021 The LEN_HI acceptance SHALL store len[15:8], then branch as follows.
REQ-022 If len == 0, the FSM SHALL move to CSUM.
REQ-023 If len > 2^ADDR_WIDTH - BASE_ADDR (oversize), the FSM SHALL move to ERROR and perform no memory writes.
REQ-024 Otherwise, the FSM SHALL move to DATA.
REQ-025 Each DATA acceptance SHALL produce, on the following cycle, mem_we=1 with mem_addr=current address and mem_wdata=accepted byte (one-cycle registered latency).
REQ-026 Each DATA acceptance SHALL increment the address, decrement the remaining count, and add the byte to an 8-bit checksum modulo 256.
REQ-027 mem_we SHALL be 0 in every cycle not following a DATA acceptance, so the write rate is at most one per cycle.
REQ-028 Acceptance of the len-th data byte SHALL move the FSM to CSUM; the address SHALL never wrap.
REQ-029 A CSUM acceptance SHALL move to DONE if the byte equals the checksum, else to ERROR; the checksum byte SHALL never be written to memory.
REQ-030 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERROR.
REQ-031 cpu_hold SHALL be 0 only in DONE.
REQ-032 DONE and ERROR SHALL persist until start or reset.
REQ-033 start and reset asserted in the same cycle SHALL resolve in favour of reset.

Reset
REQ-034 Reset SHALL force IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1, checksum=0, len=0.
REQ-035 Reset asserted mid-session SHALL abort it, and mem_we SHALL be 0 from the cycle after reset is sampled, including a write pending from the last accepted byte.

Verification
REQ-036 Nominal: start; bytes 03 00 11 22 33 66 -> writes (0,11),(1,22),(2,33) each one cycle after acceptance; then done=1, cpu_hold=0, error=0.
REQ-037 Bad checksum: start; 02 00 AA 01 00 -> two writes; then error=1, done=0, cpu_hold=1.
REQ-038 Zero length: start; 00 00 00 -> no mem_we, done=1; for the same header with checksum byte 05 -> error=1.
REQ-039 Oversize with ADDR_WIDTH=10, BASE_ADDR=0: header 01 04 (1025) -> error=1 and no write; header 00 04 (1024) plus 1024 bytes and correct checksum -> last write at address 3FF, done=1.
REQ-040 Backpressure/ignore: in_valid toggled randomly -> writes identical to the gapless case; start pulsed mid-DATA -> ignored; in_valid while IDLE -> in_ready=0 and no write.
REQ-041 Reset mid-DATA, asserted the cycle after a byte acceptance -> no mem_we afterwards and all outputs at reset values; a new start plus a valid image -> done=1.
